// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults, pointer-width helper and error codes for the FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } err_code_e;

    // One extra MSB beyond the index bits separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module   : fifo_mem
// Brief    : DEPTH x DATA_WIDTH storage, one synchronous write, one async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/fifo_flags.sv
// ============================================================================
// Module   : fifo_flags
// Brief    : FWFT FIFO with registered-pointer status flags and error pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enq,
    input  logic                          deq,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] C_AFULL  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] C_AEMPTY = PW'(AEMPTY_LVL);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("fifo_flags: DEPTH must be a power of two >= 2");
        end
        if ((AFULL_LVL < 0) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
            $error("fifo_flags: AFULL_LVL outside 0..DEPTH");
        end
        if ((AEMPTY_LVL < 0) || (AEMPTY_LVL > DEPTH)) begin : g_bad_aempty
            $error("fifo_flags: AEMPTY_LVL outside 0..DEPTH");
        end
    endgenerate

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic          overflow_q, underflow_q;
    err_code_e     err_d;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Flags come only from registered pointers; enq/deq never reach them.
    assign count        = wp_q - rp_q;
    assign empty        = (wp_q == rp_q);
    assign full         = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign almost_full  = (count >= C_AFULL);
    assign almost_empty = (count <= C_AEMPTY);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign w_wr_acc = enq && (!full || deq) && !flush;
    assign w_rd_acc = deq && !empty && !flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        err_d = ERR_NONE;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (w_wr_acc) wp_d = wp_q + 1'b1;
            if (w_rd_acc) rp_d = rp_q + 1'b1;
            if (enq && full && !deq)  err_d = ERR_OVERFLOW;
            else if (deq && empty)    err_d = ERR_UNDERFLOW;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q        <= '0;
            rp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            overflow_q  <= (err_d == ERR_OVERFLOW);
            underflow_q <= (err_d == ERR_UNDERFLOW);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk        (clk),
        .wr_en_i    (w_wr_acc),
        .wr_addr_i  (wp_q[AW-1:0]),
        .wr_data_i  (data_in),
        .rd_addr_i  (rp_q[AW-1:0]),
        .rd_data_o  (data_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_flags.sv
// ============================================================================
// Module   : tb_fifo_flags
// Brief    : Directed scoreboard bench for fifo_flags (DEPTH=16, DATA_WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_flags;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enq, deq, flush;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_empty, almost_full;
    logic [4:0]    count;
    logic          overflow, underflow;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb [$];
    logic          exp_ovf, exp_udf;

    fifo_flags #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enq          (enq),
        .deq          (deq),
        .flush        (flush),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = sb.size();
        chk("count",        32'(count),        32'(sz));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("full",         32'(full),         32'(sz == DP));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        chk("almost_full",  32'(almost_full),  32'(sz >= DP - 2));
        if (sz > 0) chk("data_out", 32'(data_out), 32'(sb[0]));
    endtask

    // One clock of stimulus: check state at negedge, apply, check pulses after edge.
    task automatic step(input logic e, input logic d, input logic f, input logic [DW-1:0] din);
        @(negedge clk);
        check_state();
        enq = e; deq = d; flush = f; data_in = din;
        exp_ovf = !f && e && !d && (sb.size() == DP);
        exp_udf = !f && d && (sb.size() == 0);
        if (f) begin
            sb.delete();
        end else begin
            if (d && sb.size() > 0) void'(sb.pop_front());
            if (e && sb.size() < DP) sb.push_back(din);
        end
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0; flush = 1'b0;
        chk("overflow",  32'(overflow),  32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_udf));
    endtask

    initial begin
        rstn = 1'b0; enq = 1'b0; deq = 1'b0; flush = 1'b0; data_in = '0;

        // Reset values, observed before any clock edge.
        #3;
        check_state();
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Fill with 0x00..0x0F; almost_full/full tracked every step.
        for (int i = 0; i < DP; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
        step(1'b0, 1'b0, 1'b0, '0);

        // Rejected write on full, then one-cycle pulse, then simultaneous push/pop.
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 1'b0, '0);

        // Drain: order must be 0x01..0x0F then 0xAA.
        for (int i = 0; i < DP; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Underflow on empty, then simultaneous push/pop while empty.
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b0, '0);

        // Random interleaved traffic crossing pointer wraps.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, DW'($urandom));

        // Flush at count 9 with a concurrent write.
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
        step(1'b1, 1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset at count 5, observed between clock edges.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
        @(negedge clk);
        check_state();
        #2;
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // First write after reset becomes the head.
        step(1'b1, 1'b0, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
